// File: rtl/cmd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmd_pkg : opcodes and acknowledge byte shared by the remote and quad ends
// Rev 1.0
// ---------------------------------------------------------------------------
package cmd_pkg;

  localparam logic [7:0] SET_PITCH = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;

  localparam logic [7:0] RESP_ACK  = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/cmd_sender.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmd_sender : sends opcode + 16-bit payload as three UART bytes, then waits
//              for the acknowledge byte or a timeout.          Rev 1.0
// ---------------------------------------------------------------------------
module cmd_sender
  import cmd_pkg::*;
#(
  parameter int FAST_SIM = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        clr_resp_rdy,
  output logic        busy,
  output logic        done,
  output logic        resp_ok,
  output logic        resp_tmo,
  output logic [7:0]  last_resp
);

  localparam int TMR_W = (FAST_SIM != 0) ? 10 : 27;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TX_CMD    = 3'd1,
    TX_HI     = 3'd2,
    TX_LO     = 3'd3,
    WAIT_RESP = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [15:0]        data_q, data_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic               tx_done_q;
  logic               tx_rise;
  logic               trmt_nxt, clr_nxt, done_nxt, ok_nxt, tmo_nxt;
  logic [7:0]         tx_data_nxt, last_nxt;

  // A level-style tx_done must advance only one byte, so act on its rising sample.
  assign tx_rise = tx_done & ~tx_done_q;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      data_q       <= '0;
      timer        <= '0;
      tx_done_q    <= 1'b0;
      trmt         <= 1'b0;
      tx_data      <= 8'h00;
      clr_resp_rdy <= 1'b0;
      done         <= 1'b0;
      resp_ok      <= 1'b0;
      resp_tmo     <= 1'b0;
      last_resp    <= 8'h00;
    end else begin
      state        <= state_nxt;
      data_q       <= data_nxt;
      timer        <= timer_nxt;
      tx_done_q    <= tx_done;
      trmt         <= trmt_nxt;
      tx_data      <= tx_data_nxt;
      clr_resp_rdy <= clr_nxt;
      done         <= done_nxt;
      resp_ok      <= ok_nxt;
      resp_tmo     <= tmo_nxt;
      last_resp    <= last_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    data_nxt    = data_q;
    timer_nxt   = timer;
    trmt_nxt    = 1'b0;
    clr_nxt     = 1'b0;
    done_nxt    = 1'b0;
    tx_data_nxt = tx_data;
    ok_nxt      = resp_ok;
    tmo_nxt     = resp_tmo;
    last_nxt    = last_resp;

    case (state)
      IDLE: begin
        if (snd_cmd) begin
          data_nxt    = data;
          tx_data_nxt = cmd;
          trmt_nxt    = 1'b1;
          ok_nxt      = 1'b0;
          tmo_nxt     = 1'b0;
          state_nxt   = TX_CMD;
        end
      end
      TX_CMD: begin
        if (tx_rise) begin
          tx_data_nxt = data_q[15:8];
          trmt_nxt    = 1'b1;
          state_nxt   = TX_HI;
        end
      end
      TX_HI: begin
        if (tx_rise) begin
          tx_data_nxt = data_q[7:0];
          trmt_nxt    = 1'b1;
          state_nxt   = TX_LO;
        end
      end
      TX_LO: begin
        if (tx_rise) begin
          timer_nxt = '0;
          state_nxt = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        // Stay one extra cycle while done is high so busy covers the done pulse
        // and the not-yet-cleared resp_rdy is not consumed twice.
        if (done) begin
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + TMR_W'(1);
          if (resp_rdy) begin
            last_nxt = resp;
            ok_nxt   = (resp == RESP_ACK);
            clr_nxt  = 1'b1;
            done_nxt = 1'b1;
          end else if (&timer) begin
            tmo_nxt  = 1'b1;
            done_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_sender.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cmd_sender : directed + randomized transactions against a transaction-
//                 level model of the command/response exchange.   Rev 1.0
// ---------------------------------------------------------------------------
module tb_cmd_sender;
  import cmd_pkg::*;

  localparam int TMO_CYC = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        snd_cmd = 1'b0;
  logic [7:0]  cmd_in = 8'h00;
  logic [15:0] data_in = 16'h0000;
  logic        tx_done = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        trmt, clr_resp_rdy, busy, done, resp_ok, resp_tmo;
  logic [7:0]  tx_data, last_resp;

  cmd_sender #(.FAST_SIM(1)) dut (
    .clk(clk), .rst_n(rst_n), .snd_cmd(snd_cmd), .cmd(cmd_in), .data(data_in),
    .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done), .resp_rdy(resp_rdy),
    .resp(resp), .clr_resp_rdy(clr_resp_rdy), .busy(busy), .done(done),
    .resp_ok(resp_ok), .resp_tmo(resp_tmo), .last_resp(last_resp)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  logic [7:0] tx_q[$];
  int trmt_cyc[$], txd_cyc[$];
  int tx_cnt = 0, resp_cnt = 0, resp_dly = 0;
  int clr_cnt = 0, done_cnt = 0, done_cyc = 0;
  bit want_resp = 1'b0;
  logic [7:0] resp_val = 8'h00;
  logic [7:0] exp_last = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at the falling edge, play the UART tx/rx roles.
  task automatic step();
    @(negedge clk);
    cyc++;
    snd_cmd = 1'b0;
    tx_done = 1'b0;
    if (clr_resp_rdy) resp_rdy = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        resp_rdy = 1'b1;
        resp     = resp_val;
      end
    end
    if (trmt) begin
      tx_q.push_back(tx_data);
      trmt_cyc.push_back(cyc);
      tx_cnt = 20;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_done = 1'b1;
        txd_cyc.push_back(cyc);
        if (txd_cyc.size() == 3 && want_resp) resp_cnt = resp_dly;
      end
    end
    if (clr_resp_rdy) clr_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic clear_obs();
    tx_q.delete(); trmt_cyc.delete(); txd_cyc.delete();
    clr_cnt = 0; done_cnt = 0; tx_cnt = 0; resp_cnt = 0;
  endtask

  task automatic run_txn(input logic [7:0] c, input logic [15:0] d, input bit respond,
                         input logic [7:0] rv, input int dly, input bit inject);
    logic [7:0] exp_b[3];
    bit  wins;
    int  n, inj, exp_dc;
    clear_obs();
    want_resp = respond; resp_val = rv; resp_dly = dly;
    exp_b[0] = c; exp_b[1] = d[15:8]; exp_b[2] = d[7:0];
    // A response counts only if it is present no later than the last timer cycle.
    wins = respond && (dly <= TMO_CYC);
    cmd_in = c; data_in = d; snd_cmd = 1'b1;
    step();
    chk("start_busy", busy, 1);
    chk("start_trmt", trmt, 1);
    chk("start_txdata", tx_data, c);
    n = 0; inj = 0;
    while (done_cnt == 0 && n < 3000) begin
      if (inject && inj == 0 && tx_q.size() == 2) begin
        cmd_in = ~c; data_in = ~d; snd_cmd = 1'b1; inj = 1;
      end else if (inject && inj == 1 && txd_cyc.size() == 3 && cyc >= txd_cyc[2] + 1) begin
        snd_cmd = 1'b1; inj = 2;
      end
      step(); n++;
    end
    chk("done_seen", done_cnt, 1);
    chk("busy_at_done", busy, 1);
    if (wins) exp_last = rv;
    chk("resp_ok", resp_ok, wins && (rv == RESP_ACK));
    chk("resp_tmo", resp_tmo, !wins);
    chk("last_resp", last_resp, exp_last);
    if (txd_cyc.size() == 3) begin
      exp_dc = wins ? (txd_cyc[2] + dly + 1) : (txd_cyc[2] + TMO_CYC + 1);
      chk("done_latency", done_cyc, exp_dc);
    end else begin
      chk("txdone_count", txd_cyc.size(), 3);
    end
    step();
    chk("busy_after", busy, 0);
    repeat (4) step();
    chk("done_once", done_cnt, 1);
    chk("clr_count", clr_cnt, wins ? 1 : 0);
    chk("byte_count", tx_q.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < tx_q.size()) chk($sformatf("byte%0d", i), tx_q[i], exp_b[i]);
    for (int i = 1; i < 3; i++)
      if (i < trmt_cyc.size() && i - 1 < txd_cyc.size())
        chk($sformatf("trmt%0d_lat", i), trmt_cyc[i], txd_cyc[i-1] + 1);
    resp_rdy = 1'b0; resp_cnt = 0; want_resp = 1'b0;
  endtask

  initial begin
    logic [7:0] rc, rr;
    logic [15:0] rd;
    int n;

    repeat (3) step();
    chk("rst_outs_low", {trmt, clr_resp_rdy, busy, done, resp_ok, resp_tmo, tx_data, last_resp}, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_outs", {trmt, clr_resp_rdy, busy, done, resp_ok, resp_tmo, tx_data, last_resp}, 0);

    run_txn(SET_PITCH, 16'h1234, 1, RESP_ACK, 10, 0);
    run_txn(SET_THRST, 16'h00FF, 1, 8'h5A, 7, 0);
    run_txn(CALIBRATE, 16'hC0DE, 0, 8'h00, 0, 0);
    run_txn(SET_ROLL, 16'hA55A, 1, RESP_ACK, 30, 1);
    run_txn(SET_YAW, 16'h0102, 1, 8'h3C, 5, 0);
    run_txn(EMER_LAND, 16'h7E81, 1, RESP_ACK, TMO_CYC, 0);
    run_txn(MTRS_OFF, 16'hFFFF, 1, RESP_ACK, TMO_CYC + 1, 0);

    // Response byte held while idle must be left alone.
    clr_cnt = 0;
    resp = 8'h33; resp_rdy = 1'b1;
    repeat (6) step();
    chk("idle_resp_noclr", clr_cnt, 0);
    chk("idle_resp_last", last_resp, exp_last);
    resp_rdy = 1'b0;

    // Reset while the last byte is in flight.
    clear_obs();
    cmd_in = SET_YAW; data_in = 16'hBEEF; snd_cmd = 1'b1;
    n = 0;
    while (tx_q.size() < 3 && n < 200) begin step(); n++; end
    step();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_outs", {trmt, clr_resp_rdy, busy, done, resp_ok, resp_tmo, tx_data, last_resp}, 0);
    repeat (25) step();
    rst_n = 1'b1;
    exp_last = 8'h00;
    repeat (3) step();
    chk("rst_no_done", done_cnt, 0);
    chk("rst_idle", busy, 0);

    run_txn(SET_PITCH, 16'h4321, 1, RESP_ACK, 12, 0);

    for (int i = 0; i < 6; i++) begin
      rc = 8'($urandom);
      rd = 16'($urandom);
      rr = ($urandom_range(0, 1) == 1) ? RESP_ACK : 8'($urandom);
      run_txn(rc, rd, 1, rr, int'($urandom_range(1, 60)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
